i2c_master_intf: RTL and testbench



---
 rtl/i2c_master_intf.sv | 190 +++++++++++++++++++
 tb/tb_i2c_master_intf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_intf.sv
// Byte-oriented open-drain I2C master for the MAX1238 readout path.
// Define I2C_CLK_STRETCH_EN to let a slave stall the bit by holding SCL low.
module i2c_master_intf #(
  parameter int CLK_FREQ = 40_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        scl_o,
  input  logic        scl_i,
  output logic        sda_o,
  input  logic        sda_i,
  input  logic        wr_flg,
  input  logic        rd_flg,
  input  logic [6:0]  adr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_bytes,
  input  logic [2:0]  rd_bytes,
  input  logic [3:0]  rd_channels,
  output logic [31:0] rd_data,
  output logic        rd_data_en,
  output logic        busy
);
  localparam int Q  = CLK_FREQ / (4 * SCL_FREQ);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ph;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic [31:0]   wbuf, acc;
  logic          rw, nack;
  logic [2:0]    wr_left, rd_len, rd_left;
  logic [3:0]    ch_left;
  logic          bit_st, stall, qend, last_rd;
  logic [2:0]    wn, rl;
  logic [3:0]    rc;

  assign bit_st = state inside {ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK};
`ifdef I2C_CLK_STRETCH_EN
  assign stall = bit_st && (ph == 2'd2) && !scl_i;
`else
  // Pure counter timing; scl_i is masked off so it never affects the bit.
  assign stall = 1'b0 & bit_st & ~scl_i;
`endif
  assign qend    = (cnt == CW'(Q - 1)) && !stall;
  assign wn      = (wr_bytes > 3'd4) ? 3'd4 : wr_bytes;
  assign rl      = (rd_bytes == 3'd0) ? 3'd1 : (rd_bytes > 3'd4) ? 3'd4 : rd_bytes;
  assign rc      = (rd_channels == 4'd0) ? 4'd1 : rd_channels;
  assign last_rd = (ch_left == 4'd1) && (rd_left == 3'd1);

  always_ff @(posedge clk) begin
    rd_data_en <= 1'b0;
    if (reset) begin
      state   <= IDLE;
      scl_o   <= 1'b1;
      sda_o   <= 1'b1;
      busy    <= 1'b0;
      rd_data <= '0;
      cnt     <= '0;
      ph      <= '0;
      bitn    <= '0;
      sh      <= '0;
      wbuf    <= '0;
      acc     <= '0;
      rw      <= 1'b0;
      nack    <= 1'b0;
      wr_left <= '0;
      rd_len  <= 3'd1;
      rd_left <= 3'd1;
      ch_left <= 4'd1;
    end else begin
      if (state != IDLE) begin
        if (qend) begin
          cnt <= '0;
          ph  <= ph + 2'd1;
        end else if (!stall) cnt <= cnt + 1'b1;
      end
      if (bit_st && qend && ph == 2'd1) scl_o <= 1'b1;
      // End of phase 2: SCL has been high for a full quarter, sample SDA.
      if (bit_st && qend && ph == 2'd2) begin
        if (state == RD_BYTE) sh <= {sh[6:0], sda_i};
        nack <= sda_i;
      end
      unique case (state)
        IDLE: begin
          busy  <= 1'b0;
          scl_o <= 1'b1;
          sda_o <= 1'b1;
          cnt   <= '0;
          ph    <= '0;
          if (wr_flg || rd_flg) begin
            state   <= START;
            rw      <= !wr_flg;
            sh      <= {adr, !wr_flg};
            wr_left <= wn;
            rd_len  <= rl;
            rd_left <= rl;
            ch_left <= rc;
            acc     <= '0;
            case (wn)
              3'd1:    wbuf <= wr_data << 24;
              3'd2:    wbuf <= wr_data << 16;
              3'd3:    wbuf <= wr_data << 8;
              default: wbuf <= wr_data;
            endcase
          end
        end
        START: begin
          busy <= 1'b1;
          if (qend && ph == 2'd0) sda_o <= 1'b0;
          if (qend && ph == 2'd2) begin
            scl_o <= 1'b0;
            sda_o <= sh[7];
            ph    <= '0;
            bitn  <= '0;
            state <= ADDR;
          end
        end
        ADDR, WR_BYTE: if (qend && ph == 2'd3) begin
          scl_o <= 1'b0;
          if (bitn == 3'd7) begin
            state <= (state == ADDR) ? ADDR_ACK : WR_ACK;
            sda_o <= 1'b1;
          end else begin
            bitn  <= bitn + 3'd1;
            sh    <= {sh[6:0], 1'b0};
            sda_o <= sh[6];
          end
        end
        ADDR_ACK, WR_ACK: if (qend && ph == 2'd3) begin
          scl_o <= 1'b0;
          bitn  <= '0;
          if (nack || (!rw && wr_left == 3'd0)) begin
            state <= STOP;
            sda_o <= 1'b0;
          end else if (rw) begin
            state <= RD_BYTE;
            sda_o <= 1'b1;
          end else begin
            state   <= WR_BYTE;
            sh      <= wbuf[31:24];
            sda_o   <= wbuf[31];
            wbuf    <= {wbuf[23:0], 8'h00};
            wr_left <= wr_left - 3'd1;
          end
        end
        RD_BYTE: if (qend && ph == 2'd3) begin
          scl_o <= 1'b0;
          if (bitn == 3'd7) begin
            state <= RD_ACK;
            acc   <= {acc[23:0], sh};
            sda_o <= last_rd;
          end else bitn <= bitn + 3'd1;
        end
        RD_ACK: if (qend && ph == 2'd3) begin
          scl_o <= 1'b0;
          bitn  <= '0;
          if (rd_left == 3'd1) begin
            rd_data    <= acc;
            rd_data_en <= 1'b1;
            acc        <= '0;
            rd_left    <= rd_len;
            ch_left    <= ch_left - 4'd1;
          end else rd_left <= rd_left - 3'd1;
          if (last_rd) begin
            state <= STOP;
            sda_o <= 1'b0;
          end else begin
            state <= RD_BYTE;
            sda_o <= 1'b1;
          end
        end
        STOP: begin
          if (qend && ph == 2'd1) scl_o <= 1'b1;
          if (qend && ph == 2'd3) begin
            sda_o <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_intf.sv
// Directed bench for i2c_master_intf: bus monitor + slave model in one process,
// expected frames and read words kept in scoreboard queues.
`timescale 1ns/1ps
module tb_i2c_master_intf;
  localparam int CLK_FREQ = 4_000_000;
  localparam int SCL_FREQ = 100_000;
  localparam int Q        = CLK_FREQ / (4 * SCL_FREQ);
  localparam int STRETCH  = 320;  // 80 us at 4 MHz

  logic        clk = 1'b0, reset, scl_o, scl_i, sda_o, sda_i;
  logic        wr_flg, rd_flg, rd_data_en, busy;
  logic [6:0]  adr;
  logic [31:0] wr_data, rd_data;
  logic [2:0]  wr_bytes, rd_bytes;
  logic [3:0]  rd_channels;
  logic        sl_sda = 1'b1, hold = 1'b0;

  assign sda_i = sda_o & sl_sda;
  assign scl_i = scl_o & ~hold;
  always #125 clk = ~clk;

  i2c_master_intf #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ)) dut (
    .clk(clk), .reset(reset), .scl_o(scl_o), .scl_i(scl_i), .sda_o(sda_o), .sda_i(sda_i),
    .wr_flg(wr_flg), .rd_flg(rd_flg), .adr(adr), .wr_data(wr_data), .wr_bytes(wr_bytes),
    .rd_bytes(rd_bytes), .rd_channels(rd_channels), .rd_data(rd_data),
    .rd_data_en(rd_data_en), .busy(busy));

  int nvec = 0, nerr = 0, cyc = 0, n_start = 0, n_stop = 0, n_rden = 0;
  int t_rise = 0, t_fall = 0, t_stop = 0, hold_cnt = 0, bc = 0, nbyte = 0, sl_len = 1;
  int s0, r0, d0, d1;
  logic pscl = 1'b1, psda = 1'b1, pbusy = 1'b0, in_tx = 1'b0, frw = 1'b0, quiet = 1'b0;
  logic sl_nack = 1'b0, stretch_arm = 1'b0;
  logic [7:0] shr = 8'h00;
  logic [7:0] sl_pat [4];
  logic [8:0]  exp_q [$];
  logic [31:0] rdq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the bus at the falling edge and act as the slave.
  task automatic tick();
    logic sda_l;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) hold = 1'b0;
    end
    sda_l = sda_i;
    if (busy === 1'b1 && pbusy === 1'b0) t_rise = cyc;
    if (busy === 1'b0 && pbusy === 1'b1) t_fall = cyc;
    if (pscl && scl_o === 1'b1 && psda && sda_l === 1'b0) begin
      in_tx = 1'b1; bc = 0; nbyte = 0; quiet = 1'b0; sl_sda = 1'b1; n_start++;
    end else if (pscl && scl_o === 1'b1 && !psda && sda_l === 1'b1) begin
      in_tx = 1'b0; sl_sda = 1'b1; n_stop++; t_stop = cyc;
    end else if (in_tx && !pscl && scl_o === 1'b1) begin
      if (stretch_arm && nbyte == 1 && bc == 3 && hold_cnt == 0) begin
        hold = 1'b1; hold_cnt = STRETCH;
      end
      if (bc < 8) begin
        shr = {shr[6:0], sda_l};
        bc++;
      end else begin
        chk($sformatf("frame%0d_avail", nbyte), exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk($sformatf("frame%0d", nbyte), {shr, sda_l}, exp_q.pop_front());
        if (nbyte == 0) frw = shr[0];
        if (sda_l) quiet = 1'b1;
        bc = 0;
        nbyte++;
      end
    end else if (in_tx && pscl && scl_o === 1'b0) begin
      if (quiet) sl_sda = 1'b1;
      else if (bc == 8) sl_sda = (nbyte == 0 || !frw) ? sl_nack : 1'b1;
      else if (frw && nbyte >= 1) begin
        b = sl_pat[(nbyte - 1) % sl_len];
        sl_sda = b[7 - bc];
      end else sl_sda = 1'b1;
    end
    if (rd_data_en === 1'b1) begin
      n_rden++;
      chk("rd_avail", rdq.size() != 0, 1);
      if (rdq.size() != 0) chk("rd_data", rd_data, rdq.pop_front());
    end
    pscl  = (scl_o === 1'b1);
    psda  = (sda_l === 1'b1);
    pbusy = (busy === 1'b1);
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < maxc) begin
      tick();
      i++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic go(input logic w);
    wr_flg = w; rd_flg = !w;
    tick();
    wr_flg = 1'b0; rd_flg = 1'b0;
    tick();
    wait_idle(6000);
  endtask

  initial begin
    reset = 1'b1; wr_flg = 1'b0; rd_flg = 1'b0; adr = '0; wr_data = '0;
    wr_bytes = '0; rd_bytes = 3'd1; rd_channels = 4'd1;
    sl_pat[0] = 8'h0F; sl_pat[1] = 8'h12; sl_pat[2] = 8'h00; sl_pat[3] = 8'h00;
    repeat (3) tick();
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_en", rd_data_en, 0);
    reset = 1'b0;
    tick();

    // Write, with wr_flg and rd_flg together: write wins
    adr = 7'h35; wr_bytes = 3'd2; wr_data = 32'h0000D2A5; rd_bytes = 3'd2; rd_channels = 4'd4;
    exp_q.push_back({8'h6A, 1'b0}); exp_q.push_back({8'hD2, 1'b0}); exp_q.push_back({8'hA5, 1'b0});
    s0 = n_start; r0 = n_rden;
    wr_flg = 1'b1; rd_flg = 1'b1;
    tick();
    wr_flg = 1'b0; rd_flg = 1'b0;
    chk("busy_at_accept", busy, 0);
    tick();
    chk("busy_rise", busy, 1);
    repeat (Q - 2) tick();
    chk("start_sda_hold", sda_o, 1);
    tick();
    chk("start_sda_fall", sda_o, 0);
    chk("start_scl_high", scl_o, 1);
    repeat (50) tick();
    rd_flg = 1'b1;
    tick();
    rd_flg = 1'b0;
    wait_idle(6000);
    chk("wr_frames_left", exp_q.size(), 0);
    chk("wr_no_rden", n_rden - r0, 0);
    chk("busy_fall_lat", t_fall - t_stop, 1);
    repeat (30) tick();
    chk("rd_while_busy_ignored", n_start - s0, 1);
    chk("idle_after_ignored", busy, 0);

    // Read: 4 channels x 2 bytes
    adr = 7'h35; rd_bytes = 3'd2; rd_channels = 4'd4; sl_pat[0] = 8'h0F; sl_pat[1] = 8'h12; sl_len = 2;
    exp_q.push_back({8'h6B, 1'b0});
    for (int ch = 0; ch < 4; ch++) begin
      exp_q.push_back({8'h0F, 1'b0});
      exp_q.push_back({8'h12, (ch == 3) ? 1'b1 : 1'b0});
      rdq.push_back(32'h00000F12);
    end
    r0 = n_rden;
    go(1'b0);
    chk("rd_frames_left", exp_q.size(), 0);
    chk("rd_words_left", rdq.size(), 0);
    chk("rd_pulses", n_rden - r0, 4);

    // Address NACK on a write
    sl_nack = 1'b1; wr_bytes = 3'd2;
    exp_q.push_back({8'h6A, 1'b1});
    s0 = n_stop; r0 = n_rden;
    go(1'b1);
    sl_nack = 1'b0;
    chk("nack_frames_left", exp_q.size(), 0);
    chk("nack_len", t_fall - t_rise, 43 * Q);
    chk("nack_stop", n_stop - s0, 1);
    chk("nack_no_rden", n_rden - r0, 0);

    // Single-byte read, then same read with SCL held low mid-byte
    rd_bytes = 3'd1; rd_channels = 4'd0; sl_pat[0] = 8'hC3; sl_len = 1;
    exp_q.push_back({8'h6B, 1'b0}); exp_q.push_back({8'hC3, 1'b1}); rdq.push_back(32'h000000C3);
    go(1'b0);
    d0 = t_fall - t_rise;
    chk("rd1_len", d0, 79 * Q);
    exp_q.push_back({8'h6B, 1'b0}); exp_q.push_back({8'hC3, 1'b1}); rdq.push_back(32'h000000C3);
    stretch_arm = 1'b1;
    go(1'b0);
    stretch_arm = 1'b0;
    d1 = t_fall - t_rise;
`ifdef I2C_CLK_STRETCH_EN
    chk("stretch_extra", d1 - d0, STRETCH);
`else
    chk("stretch_extra", d1 - d0, 0);
`endif
    chk("stretch_frames_left", exp_q.size(), 0);
    chk("stretch_words_left", rdq.size(), 0);

    // Reset in the middle of the address byte
    adr = 7'h35; wr_bytes = 3'd2;
    wr_flg = 1'b1;
    tick();
    wr_flg = 1'b0;
    repeat (3 * Q + 15 * Q) tick();
    reset = 1'b1;
    tick();
    chk("midrst_scl", scl_o, 1);
    chk("midrst_sda", sda_o, 1);
    chk("midrst_busy", busy, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Address-only probe, then oversize wr_bytes clamped to 4
    adr = 7'h12; wr_bytes = 3'd0;
    exp_q.push_back({8'h24, 1'b0});
    go(1'b1);
    chk("probe_frames_left", exp_q.size(), 0);
    wr_bytes = 3'd7; wr_data = 32'h11223344;
    exp_q.push_back({8'h24, 1'b0});
    exp_q.push_back({8'h11, 1'b0}); exp_q.push_back({8'h22, 1'b0});
    exp_q.push_back({8'h33, 1'b0}); exp_q.push_back({8'h44, 1'b0});
    go(1'b1);
    chk("clamp_frames_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
